// File: rtl/rename_free_list_ctrl.sv
// Rename-stage free physical-register list: four-lane all-or-nothing tag allocation,
// commit-driven release with gap compression, and speculative-head restore on flush.
module rename_free_list_ctrl #(
    parameter int PREG_NUM = 64,
    parameter int AREG_NUM = 32,
    parameter int LANES    = 4,
    localparam int TW = $clog2(PREG_NUM),
    localparam int D  = PREG_NUM - AREG_NUM,
    localparam int IW = $clog2(D),
    localparam int PW = IW + 1
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic [LANES-1:0] InAllocReq,
    output logic             OutAllocOk,
    output logic [TW-1:0]    OutAllocTag0,
    output logic [TW-1:0]    OutAllocTag1,
    output logic [TW-1:0]    OutAllocTag2,
    output logic [TW-1:0]    OutAllocTag3,
    input  logic [LANES-1:0] InRelValid,
    input  logic [TW-1:0]    InRelTag0,
    input  logic [TW-1:0]    InRelTag1,
    input  logic [TW-1:0]    InRelTag2,
    input  logic [TW-1:0]    InRelTag3,
    input  logic [2:0]       InCmtAllocNum,
    input  logic             InFlush,
    output logic [PW-1:0]    OutFreeCnt,
    output logic             OutStall
);
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ZERO_P  = {PW{1'b0}};
    localparam logic [PW-1:0] DEPTH_P = PW'(D);

    // Number of set bits of vec strictly below position upto (lane/slot offset).
    function automatic logic [PW-1:0] count_below(input logic [LANES-1:0] vec, input int upto);
        logic [PW-1:0] cnt;
        cnt = ZERO_P;
        for (int k = 0; k < LANES; k++) begin
            if (k < upto && vec[k]) cnt = cnt + ONE_P;
            else                    cnt = cnt;
        end
        return cnt;
    endfunction

    logic [TW-1:0] mem_q [D];
    logic [TW-1:0] mem_d [D];
    logic [PW-1:0] spec_head_q, spec_head_d;
    logic [PW-1:0] arch_head_q, arch_head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [PW-1:0] free_cnt_s;
    logic [PW-1:0] alloc_n_s;
    logic [PW-1:0] rel_n_s;
    logic [PW-1:0] cmt_ext_s;
    logic          grant_s;
    logic [PW-1:0] alloc_ptr_s [LANES];
    logic [PW-1:0] rel_ptr_s   [LANES];
    logic [TW-1:0] alloc_tag_s [LANES];
    logic [TW-1:0] rel_tag_s   [LANES];

    assign rel_tag_s[0] = InRelTag0;
    assign rel_tag_s[1] = InRelTag1;
    assign rel_tag_s[2] = InRelTag2;
    assign rel_tag_s[3] = InRelTag3;

    // Zero-cycle grant: sees the count before this cycle's release lands.
    always_comb begin
        free_cnt_s = tail_q - spec_head_q;
        alloc_n_s  = count_below(InAllocReq, LANES);
        grant_s    = !Rest && !InFlush && (alloc_n_s <= free_cnt_s);
        for (int k = 0; k < LANES; k++) begin
            alloc_ptr_s[k] = spec_head_q + count_below(InAllocReq, k);
            alloc_tag_s[k] = (grant_s && InAllocReq[k]) ? mem_q[alloc_ptr_s[k][IW-1:0]]
                                                        : {TW{1'b0}};
        end
    end

    assign OutAllocOk   = grant_s;
    assign OutStall     = !Rest && (alloc_n_s != ZERO_P) && !grant_s;
    assign OutFreeCnt   = free_cnt_s;
    assign OutAllocTag0 = alloc_tag_s[0];
    assign OutAllocTag1 = alloc_tag_s[1];
    assign OutAllocTag2 = alloc_tag_s[2];
    assign OutAllocTag3 = alloc_tag_s[3];

    // Pointer advance and gap-compressed release writes.
    always_comb begin
        cmt_ext_s   = {{(PW-3){1'b0}}, InCmtAllocNum};
        rel_n_s     = count_below(InRelValid, LANES);
        arch_head_d = arch_head_q + cmt_ext_s;
        tail_d      = tail_q + rel_n_s;
        if (InFlush)      spec_head_d = arch_head_d;
        else if (grant_s) spec_head_d = spec_head_q + alloc_n_s;
        else              spec_head_d = spec_head_q;
        for (int k = 0; k < LANES; k++) begin
            rel_ptr_s[k] = tail_q + count_below(InRelValid, k);
        end
        mem_d = mem_q;
        // An invalid slot shares its index with the next valid one, so it rewrites the current value.
        for (int k = 0; k < LANES; k++) begin
            mem_d[rel_ptr_s[k][IW-1:0]] = InRelValid[k] ? rel_tag_s[k]
                                                        : mem_d[rel_ptr_s[k][IW-1:0]];
        end
    end

    // State registers with synchronous reset to the full initial free list.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            for (int e = 0; e < D; e++) begin
                mem_q[e] <= TW'(AREG_NUM + e);
            end
            spec_head_q <= ZERO_P;
            arch_head_q <= ZERO_P;
            tail_q      <= DEPTH_P;
        end else begin
            mem_q       <= mem_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
        end
    end
endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Self-checking bench: a queue-based free/in-flight/retired tag model compared every cycle,
// plus directed literal expectations for the key scenarios.
module tb_rename_free_list_ctrl;
    logic       Clk = 1'b0;
    logic       Rest;
    logic [3:0] InAllocReq, InRelValid;
    logic [5:0] InRelTag0, InRelTag1, InRelTag2, InRelTag3;
    logic [2:0] InCmtAllocNum;
    logic       InFlush;
    logic       OutAllocOk, OutStall;
    logic [5:0] OutAllocTag0, OutAllocTag1, OutAllocTag2, OutAllocTag3;
    logic [5:0] OutFreeCnt;

    rename_free_list_ctrl dut (
        .Clk(Clk), .Rest(Rest), .InAllocReq(InAllocReq), .OutAllocOk(OutAllocOk),
        .OutAllocTag0(OutAllocTag0), .OutAllocTag1(OutAllocTag1),
        .OutAllocTag2(OutAllocTag2), .OutAllocTag3(OutAllocTag3),
        .InRelValid(InRelValid), .InRelTag0(InRelTag0), .InRelTag1(InRelTag1),
        .InRelTag2(InRelTag2), .InRelTag3(InRelTag3), .InCmtAllocNum(InCmtAllocNum),
        .InFlush(InFlush), .OutFreeCnt(OutFreeCnt), .OutStall(OutStall)
    );

    always #5 Clk = ~Clk;

    logic [5:0] tag_s [4];
    always_comb begin
        tag_s[0] = OutAllocTag0;
        tag_s[1] = OutAllocTag1;
        tag_s[2] = OutAllocTag2;
        tag_s[3] = OutAllocTag3;
    end

    // Model: free tags in allocation order, allocated-uncommitted tags, committed tags.
    int free_q[$];
    int infl_q[$];
    int ret_q[$];

    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    bit   exp_ok, exp_stall;
    int   exp_cnt;
    int   exp_tag [4];
    logic [3:0] exp_req;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        infl_q.delete();
        ret_q.delete();
        for (int i = 0; i < 32; i++) begin
            free_q.push_back(32 + i);
            ret_q.push_back(i);
        end
    endtask

    // Apply inputs after a rising edge, derive expectations from the model, settle to negedge+1.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] relv,
                         input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                         input logic [5:0] t3, input logic [2:0] cmt, input logic fl);
        int n;
        int j;
        Rest = rst; InAllocReq = req; InRelValid = relv;
        InRelTag0 = t0; InRelTag1 = t1; InRelTag2 = t2; InRelTag3 = t3;
        InCmtAllocNum = cmt; InFlush = fl;
        n         = $countones(req);
        exp_cnt   = free_q.size();
        exp_ok    = !rst && !fl && (n <= exp_cnt);
        exp_stall = !rst && (n != 0) && !exp_ok;
        exp_req   = req;
        j = 0;
        for (int k = 0; k < 4; k++) begin
            exp_tag[k] = -1;
            if (req[k]) begin
                if (j < free_q.size()) exp_tag[k] = free_q[j];
                j++;
            end
        end
        @(negedge Clk);
        #1;
    endtask

    // Advance the model across the rising edge using the held inputs.
    task automatic tick();
        int rt [4];
        @(posedge Clk);
        rt[0] = InRelTag0; rt[1] = InRelTag1; rt[2] = InRelTag2; rt[3] = InRelTag3;
        if (Rest) begin
            model_reset();
        end else begin
            assert (free_q.size() + $countones(InRelValid) <= 32)
                else $error("protocol: free count plus releases exceeds depth");
            assert (InCmtAllocNum <= 3'd4 && int'(InCmtAllocNum) <= infl_q.size())
                else $error("protocol: commit count out of range");
            if (exp_ok) begin
                for (int i = 0; i < $countones(InAllocReq); i++) infl_q.push_back(free_q.pop_front());
            end
            for (int i = 0; i < int'(InCmtAllocNum); i++) ret_q.push_back(infl_q.pop_front());
            if (InFlush) begin
                while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
            end
            for (int k = 0; k < 4; k++) begin
                if (InRelValid[k]) begin
                    for (int i = 0; i < ret_q.size(); i++) begin
                        if (ret_q[i] == rt[k]) begin
                            ret_q.delete(i);
                            break;
                        end
                    end
                    free_q.push_back(rt[k]);
                end
            end
        end
        #1;
    endtask

    task automatic alloc_cycle(input logic [3:0] req);
        drive(1'b0, req, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        tick();
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("alloc_ok", int'(OutAllocOk), int'(exp_ok));
            chk("stall", int'(OutStall), int'(exp_stall));
            chk("free_cnt", int'(OutFreeCnt), exp_cnt);
            chk("conservation", int'(OutFreeCnt) + infl_q.size() + ret_q.size(), 64);
            for (int k = 0; k < 4; k++) begin
                if (exp_ok && exp_req[k]) chk("alloc_tag", int'(tag_s[k]), exp_tag[k]);
            end
        end
    end

    initial begin
        logic [3:0] m;
        logic [5:0] t [4];
        int         surplus;
        int         j;
        int         cmax;

        Rest = 1'b1; InAllocReq = 4'd0; InRelValid = 4'd0;
        InRelTag0 = 6'd0; InRelTag1 = 6'd0; InRelTag2 = 6'd0; InRelTag3 = 6'd0;
        InCmtAllocNum = 3'd0; InFlush = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        chk_en = 1'b1;

        // Reset state.
        drive(1'b1, 4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("rst_ok", int'(OutAllocOk), 0);
        chk("rst_stall", int'(OutStall), 0);
        chk("rst_cnt", int'(OutFreeCnt), 32);
        chk("rst_tag0", int'(OutAllocTag0), 0);
        tick();

        // Four-lane grant straight out of reset.
        drive(1'b0, 4'b1111, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("first_ok", int'(OutAllocOk), 1);
        chk("first_tag0", int'(OutAllocTag0), 32);
        chk("first_tag1", int'(OutAllocTag1), 33);
        chk("first_tag2", int'(OutAllocTag2), 34);
        chk("first_tag3", int'(OutAllocTag3), 35);
        tick();
        drive(1'b0, 4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("cnt_after4", int'(OutFreeCnt), 28);
        tick();

        // Drain to 2, then all-or-nothing deny and a sparse grant.
        for (int i = 0; i < 6; i++) alloc_cycle(4'b1111);
        alloc_cycle(4'b0011);
        drive(1'b0, 4'b0111, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("deny_ok", int'(OutAllocOk), 0);
        chk("deny_stall", int'(OutStall), 1);
        tick();
        drive(1'b0, 4'b0101, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("deny_cnt_kept", int'(OutFreeCnt), 2);
        chk("sparse_ok", int'(OutAllocOk), 1);
        chk("sparse_tag0", int'(OutAllocTag0), 62);
        chk("sparse_tag2", int'(OutAllocTag2), 63);
        tick();

        // Empty list: release in the same cycle is not visible to allocation.
        drive(1'b0, 4'b0001, 4'b1010, 6'd7, 6'd5, 6'd11, 6'd9, 3'd0, 1'b0);
        chk("empty_cnt", int'(OutFreeCnt), 0);
        chk("nobypass_ok", int'(OutAllocOk), 0);
        tick();
        drive(1'b0, 4'b0001, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("rel_tag_a", int'(OutAllocTag0), 5);
        tick();
        drive(1'b0, 4'b0001, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("rel_tag_b", int'(OutAllocTag0), 9);
        tick();

        // Reset mid-stream with pending alloc/release/commit.
        drive(1'b1, 4'b1111, 4'b0011, 6'd1, 6'd2, 6'd0, 6'd0, 3'd2, 1'b0);
        chk("midrst_ok", int'(OutAllocOk), 0);
        tick();
        drive(1'b0, 4'b0001, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("midrst_cnt", int'(OutFreeCnt), 32);
        chk("midrst_tag", int'(OutAllocTag0), 32);
        tick();

        // Twelve allocated, commit four with flush: eight speculative tags return.
        alloc_cycle(4'b1111);
        alloc_cycle(4'b1111);
        alloc_cycle(4'b0111);
        drive(1'b0, 4'b1111, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd4, 1'b1);
        chk("flush_ok", int'(OutAllocOk), 0);
        tick();
        drive(1'b0, 4'b1111, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0, 1'b0);
        chk("flush_cnt", int'(OutFreeCnt), 28);
        chk("flush_tag0", int'(OutAllocTag0), 36);
        chk("flush_tag1", int'(OutAllocTag1), 37);
        chk("flush_tag2", int'(OutAllocTag2), 38);
        chk("flush_tag3", int'(OutAllocTag3), 39);
        tick();

        // Long mixed traffic across several pointer wraps.
        for (int c = 0; c < 400; c++) begin
            surplus = ret_q.size() - 32;
            m = 4'($urandom_range(0, 15));
            if ($countones(m) > surplus) m = 4'd0;
            j = 0;
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    t[k] = 6'(ret_q[j]);
                    j++;
                end else begin
                    t[k] = 6'($urandom_range(0, 63));
                end
            end
            cmax = (infl_q.size() < 4) ? infl_q.size() : 4;
            drive(1'b0, 4'($urandom_range(0, 15)), m, t[0], t[1], t[2], t[3],
                  3'($urandom_range(0, cmax)), ($urandom_range(0, 15) == 0));
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
